// File: rtl/ram_pair_loader.sv
// ram_pair_loader
//   Collects a byte stream of 256 four-byte groups and writes each group into
//   two dual-port RAMs (RAM0 holds array A, RAM1 holds array B) in a single
//   write cycle. Group k carries A[k], A[511-k], B[k], B[511-k]. Port A of
//   both RAMs addresses k and port B addresses 511-k, so every group becomes
//   one simultaneous write on all four RAM ports.
//
// Ports
//   CLOCK_I          clock, rising edge
//   RESETN_I         asynchronous active-low reset
//   START_I          one-cycle pulse that begins a load (only from idle/done)
//   DATA_I, VALID_I  input byte stream
//   READY_O          byte on DATA_I is accepted when VALID_I && READY_O
//   ADDRESS_A_O      port-A address (group index k), shared by both RAMs
//   ADDRESS_B_O      port-B address, always ~ADDRESS_A_O (= 511-k)
//   WRITE_DATA_A_O   port-A write data, [0] = RAM0, [1] = RAM1
//   WRITE_DATA_B_O   port-B write data, [0] = RAM0, [1] = RAM1
//   WRITE_ENABLE_O   write strobe common to all four RAM ports
//   BUSY_O           load in progress
//   DONE_O           load complete, held until the next START_I
module ram_pair_loader (
  input  logic            CLOCK_I,
  input  logic            RESETN_I,
  input  logic            START_I,
  input  logic [7:0]      DATA_I,
  input  logic            VALID_I,
  output logic            READY_O,
  output logic [8:0]      ADDRESS_A_O,
  output logic [8:0]      ADDRESS_B_O,
  output logic [1:0][7:0] WRITE_DATA_A_O,
  output logic [1:0][7:0] WRITE_DATA_B_O,
  output logic            WRITE_ENABLE_O,
  output logic            BUSY_O,
  output logic            DONE_O
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            ready_q, busy_q, we_q, done_q;
  logic [8:0]      addr_q;
  logic [1:0]      cnt_q;
  logic [1:0][7:0] wda_q, wdb_q;

  logic accept;
  logic start_load;
  logic last_group;

  // READY_O is high exactly in S_COLLECT, so it doubles as the accept qualifier.
  assign accept     = VALID_I && ready_q;
  assign start_load = START_I && ((state_q == S_IDLE) || (state_q == S_DONE));
  // Bit 8 of the address never sets, so the group index is its low byte.
  assign last_group = (addr_q[7:0] == 8'hFF);

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (START_I) state_d = S_COLLECT;
      S_COLLECT:      if (accept && (cnt_q == 2'd3)) state_d = S_WRITE;
      S_WRITE:        state_d = last_group ? S_DONE : S_COLLECT;
      default:        state_d = S_IDLE;
    endcase
  end

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Status outputs are flops loaded from the next state, so they line up
  // with the state register instead of trailing it by a cycle.
  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (state_d == S_COLLECT);
      busy_q  <= (state_d == S_COLLECT) || (state_d == S_WRITE);
      we_q    <= (state_d == S_WRITE);
      done_q  <= (state_d == S_DONE);
    end
  end

  // NOTE: the four data bytes are ordinary registers, not a memory, so they
  // are reset along with everything else and read zero after an abort.
  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      addr_q <= '0;
      cnt_q  <= '0;
      wda_q  <= '0;
      wdb_q  <= '0;
    end else begin
      if (start_load) begin
        addr_q <= '0;
        cnt_q  <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 2'd1;
        // Byte order within a group is A[k], A[511-k], B[k], B[511-k].
        case (cnt_q)
          2'd0:    wda_q[0] <= DATA_I;
          2'd1:    wdb_q[0] <= DATA_I;
          2'd2:    wda_q[1] <= DATA_I;
          default: wdb_q[1] <= DATA_I;
        endcase
      end else if ((state_q == S_WRITE) && !last_group) begin
        // Advance after the write; the last group keeps its address.
        addr_q <= addr_q + 9'd1;
      end
    end
  end

  assign READY_O        = ready_q;
  assign BUSY_O         = busy_q;
  assign WRITE_ENABLE_O = we_q;
  assign DONE_O         = done_q;
  assign ADDRESS_A_O    = addr_q;
  assign ADDRESS_B_O    = ~addr_q;
  assign WRITE_DATA_A_O = wda_q;
  assign WRITE_DATA_B_O = wdb_q;

endmodule

// File: tb/tb_ram_pair_loader.sv
// tb_ram_pair_loader
//   Scoreboard bench for ram_pair_loader. The driver pushes one expected
//   write (address and four data bytes) per group it sends; a monitor on the
//   falling edge pops and compares on every WRITE_ENABLE_O cycle.
module tb_ram_pair_loader;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [7:0]      data;
  logic            valid;
  logic            ready;
  logic [8:0]      addr_a, addr_b;
  logic [1:0][7:0] wda, wdb;
  logic            we, busy, done;

  ram_pair_loader dut (
    .CLOCK_I        (clk),
    .RESETN_I       (rst_n),
    .START_I        (start),
    .DATA_I         (data),
    .VALID_I        (valid),
    .READY_O        (ready),
    .ADDRESS_A_O    (addr_a),
    .ADDRESS_B_O    (addr_b),
    .WRITE_DATA_A_O (wda),
    .WRITE_DATA_B_O (wdb),
    .WRITE_ENABLE_O (we),
    .BUSY_O         (busy),
    .DONE_O         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] bytes;  // {A[k], A[511-k], B[k], B[511-k]}
  } wr_t;

  wr_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int load_start;
  int last_we;
  int n_writes;
  bit spacing_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every write cycle must match the oldest expected group.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("addr_a", {23'd0, addr_a}, {23'd0, e.addr});
        check("addr_b", {23'd0, addr_b}, {23'd0, 9'd511 - e.addr});
        check("wdata", {wda[0], wdb[0], wda[1], wdb[1]}, e.bytes);
      end
      if (spacing_en) begin
        if (n_writes == 0) check("first_write_latency", cyc - load_start, 32'd4);
        else               check("write_spacing", cyc - last_we, 32'd5);
      end
      last_we = cyc;
      n_writes++;
    end
  end

  // All driver tasks are entered and left on a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    load_start = cyc;
    n_writes   = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    repeat (gap) begin
      valid = 1'b0;
      @(negedge clk);
    end
    valid  = 1'b1;
    data   = b;
    budget = 0;
    while (!ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);  // the rising edge in between accepted the byte
  endtask

  // Stream bytes are (stream index mod 256), so group k carries 4k..4k+3.
  task automatic send_group(input int k, input int nbytes, input bit throttle);
    wr_t e;
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'((4 * k + i) % 256);
      if (i == 3) begin
        e.addr  = 9'(k);
        e.bytes = {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
        exp_q.push_back(e);
      end
      send_byte(b, throttle ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    valid = 1'b0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    spacing_en = 1'b0;
    n_writes   = 0;
    last_we    = 0;
    load_start = 0;

    // Reset state.
    #12;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_addr_a", {23'd0, addr_a}, 32'd0);
    check("rst_addr_b", {23'd0, addr_b}, 32'd511);
    check("rst_wdata", {wda, wdb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // VALID in S_IDLE is ignored.
    valid = 1'b1;
    data  = 8'hAA;
    repeat (4) @(negedge clk);
    check("idle_ready", {31'd0, ready}, 32'd0);
    valid = 1'b0;

    // Full load with VALID held high.
    spacing_en = 1'b1;
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 256; k++) send_group(k, 4, 1'b0);
    wait_done();
    check("done_latency", cyc - load_start, 32'd1280);
    check("last_write_cycle", last_we - load_start, 32'd1279);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_addr_a", {23'd0, addr_a}, 32'd255);
    check("full_writes", n_writes, 32'd256);
    check("full_queue_empty", exp_q.size(), 32'd0);

    // VALID in S_DONE is ignored; DONE holds.
    valid = 1'b1;
    repeat (10) @(negedge clk);
    check("done_ready", {31'd0, ready}, 32'd0);
    check("done_held", {31'd0, done}, 32'd1);
    check("no_writes_after_done", n_writes, 32'd256);
    valid = 1'b0;

    // Reload from S_DONE, then a throttled stream.
    spacing_en = 1'b0;
    pulse_start();
    check("reload_done", {31'd0, done}, 32'd0);
    check("reload_addr_a", {23'd0, addr_a}, 32'd0);
    check("reload_ready", {31'd0, ready}, 32'd1);
    for (int k = 0; k < 256; k++) send_group(k, 4, 1'b1);
    wait_done();
    check("throttled_writes", n_writes, 32'd256);
    check("throttled_queue_empty", exp_q.size(), 32'd0);

    // Stray START/VALID during S_WRITE.
    pulse_start();
    send_group(0, 4, 1'b0);
    check("in_write", {31'd0, we}, 32'd1);
    start = 1'b1;
    valid = 1'b1;
    data  = 8'hEE;
    check("write_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("no_restart_addr", {23'd0, addr_a}, 32'd1);
    check("no_restart_ready", {31'd0, ready}, 32'd1);
    for (int k = 1; k < 7; k++) send_group(k, 4, 1'b0);

    // Reset after two bytes of group 7.
    send_group(7, 2, 1'b0);
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    check("abort_outputs", {23'd0, addr_a, ready, busy, done, we}, 32'd0);
    check("abort_wdata", {wda, wdb}, 32'd0);
    check("abort_writes", n_writes, 32'd7);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {31'd0, ready}, 32'd0);
    pulse_start();
    send_group(0, 4, 1'b0);
    @(negedge clk);
    check("post_reset_writes", n_writes, 32'd1);
    check("post_reset_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
